axis_unconcat: RTL and testbench
================================

AXIS_UNCONCAT -- requirements
Module: axis_unconcat

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width in bits.
REQ-002 SHALL have parameter ENABLE_LAST, default 1: nonzero means a TLAST bit is packed in left_TDATA.
REQ-003 SHALL have parameter ENABLE_KEEP, default 0: nonzero means a KEEP field of (DATA_WIDTH+7)/8 bits is packed.
REQ-004 SHALL have parameters ENABLE_DEST / DEST_WIDTH, defaults 0 / 16: packed DEST field presence and width.
REQ-005 SHALL have parameters ENABLE_ID / ID_WIDTH, defaults 0 / 16: packed ID field presence and width.
REQ-006 SHALL have parameters ENABLE_USER / USER_WIDTH, defaults 0 / 16: packed USER field presence and width.
REQ-007 SHALL have one clock and a synchronous active-high reset: clk in 1 (all logic on rising edge); rst in 1 (synchronous, active-high).
REQ-008 SHALL have left_TDATA in PW, packed word; PW = DATA_WIDTH plus the widths of all enabled fields.
REQ-009 SHALL have left_TVALID in 1; left_TREADY out 1.
REQ-010 SHALL have right_TDATA out DATA_WIDTH; right_TVALID out 1; right_TREADY in 1; right_TLAST out 1.
REQ-011 SHALL have right_TKEEP, right_TDEST, right_TID, right_TUSER as outputs; each field is its enabled width, or 1 bit when disabled.

Function
REQ-012 SHALL unpack left_TDATA MSB-first as {DATA, LAST, KEEP, DEST, ID, USER}, with disabled fields occupying zero bits and USER at bit 0.
REQ-013 SHALL drive disabled side outputs as constants: right_TLAST=1, right_TKEEP=all ones, right_TDEST/TID/TUSER=0.
REQ-014 SHALL implement a 2-entry skid buffer (main register, skid register) so that all right_* outputs and left_TREADY come directly from flops.
REQ-015 SHALL accept an input beat on a cycle where left_TVALID and left_TREADY are both high, and SHALL deliver an output beat on a cycle where right_TVALID and right_TREADY are both high.
REQ-016 SHALL have latency exactly 1 cycle: a beat accepted at edge N with the main register free appears on right_* after edge N.
REQ-017 SHALL sustain throughput of 1 beat/cycle while right_TREADY is held high.
REQ-018 SHALL implement these states:
- EMPTY: main invalid, skid invalid.
- ONE: main valid, skid invalid.
- FULL: main valid, skid valid.
REQ-019 SHALL make these transitions:
- EMPTY + accept -> ONE.
- ONE + accept without output handshake -> FULL, with the beat captured in skid.
- ONE + output handshake without accept -> EMPTY.
- ONE + accept and output handshake -> ONE, with main reloaded.
- FULL + output handshake -> ONE, with skid moved to main.
REQ-020 SHALL register left_TREADY as high exactly when the next state is not FULL, so FULL is never overrun.
REQ-021 SHALL hold right_* stable while right_TVALID=1 and right_TREADY=0 (AXI-Stream rule).
REQ-022 SHALL never combinationally depend right_TVALID on right_TREADY, nor left_TREADY on left_TVALID.
REQ-023 SHALL preserve beat order; no beat is dropped or duplicated.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, clear the main and skid valid flags (state EMPTY), set right_TVALID=0, and set left_TREADY=0.
REQ-025 SHALL raise left_TREADY on the first edge with rst=0.
REQ-026 SHALL discard any beats in flight when reset is asserted mid-transfer, and produce no output beat until new input is accepted.
REQ-027 SHALL reset no data-path flops (valid flags and ready only).

Structure
REQ-028 SHALL place field-width and offset computation (KEEP width, per-field LSB offsets, PW) in a shared include, usable by the matching packer.
REQ-029 SHALL contain one sub-module, axis_skid (generic WIDTH-bit 2-entry register slice), instantiated on the packed word; unpacking is wiring after it.

Verification
REQ-030 SHALL be covered by these directed scenarios (defaults plus ENABLE_KEEP=1):
- Bench SHALL inject left_TDATA=0xDEADBEEF_1_F with ready held high -> next cycle right_TDATA=0xDEADBEEF, right_TLAST=1, right_TKEEP=0xF.
- Bench SHALL drive 8 back-to-back beats with right_TREADY=1 -> 8 outputs on consecutive cycles, in order.
- Bench SHALL drop right_TREADY low for 3 cycles during streaming -> left_TREADY falls after 2 beats buffered, outputs held stable, no loss after release.
- Bench SHALL set ENABLE_DEST=1, DEST_WIDTH=4, word {0x12345678,0,0x3,0xA} -> right_TDEST=0xA, right_TLAST=0.
- Bench SHALL assert rst in FULL -> next cycle right_TVALID=0 and left_TREADY=0; left_TREADY=1 one cycle after rst=0; stale beats never appear.
- Bench SHALL apply random valid/ready over 10k beats -> scoreboard matches and no protocol-assertion failures.

Source files
------------

// File: rtl/axis_unconcat_pkg.sv
// Shared definitions for the AXI-Stream packer/unpacker pair.
// The field layout math lives here so the matching packer computes the
// same offsets. Packed word layout, MSB first:
//   {DATA, LAST, KEEP, DEST, ID, USER}
// Disabled fields take zero bits, and USER sits at bit 0.
package axis_unconcat_pkg;

    // Selects a field for field_lsb(); FLD_END returns the total packed width
    typedef enum logic [2:0] {
        FLD_USER,
        FLD_ID,
        FLD_DEST,
        FLD_KEEP,
        FLD_LAST,
        FLD_DATA,
        FLD_END
    } fld_e;

    // Register-slice occupancy
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } skid_state_e;

    // One KEEP bit per (possibly partial) byte of payload
    function automatic int keep_w(input int data_w);
        return (data_w + 7) / 8;
    endfunction

    // Width a field occupies in the packed word
    function automatic int fld_w(input int en, input int w);
        return (en != 0) ? w : 0;
    endfunction

    // Width of the matching side-band port (1 bit when the field is absent)
    function automatic int port_w(input int en, input int w);
        return (en != 0) ? w : 1;
    endfunction

    // LSB offset of a field inside the packed word; FLD_END yields PW
    function automatic int field_lsb(
        input fld_e sel,
        input int   data_w,
        input int   en_last,
        input int   en_keep,
        input int   en_dest,
        input int   dest_w,
        input int   en_id,
        input int   id_w,
        input int   en_user,
        input int   user_w
    );
        int off;
        off = 0;
        if (sel == FLD_USER) return off;
        off += fld_w(en_user, user_w);
        if (sel == FLD_ID) return off;
        off += fld_w(en_id, id_w);
        if (sel == FLD_DEST) return off;
        off += fld_w(en_dest, dest_w);
        if (sel == FLD_KEEP) return off;
        off += fld_w(en_keep, keep_w(data_w));
        if (sel == FLD_LAST) return off;
        off += fld_w(en_last, 1);
        if (sel == FLD_DATA) return off;
        off += data_w;
        return off;
    endfunction

endpackage

// File: rtl/axis_unconcat_if.sv
// Stream bundle for the unpacker. The left side carries the packed word
// in, and the right side carries the split AXI-Stream beat out. The slave
// modport is the unpacker's view; master is the surrounding logic's view.
interface axis_unconcat_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PW         = 33,
    parameter int KEEP_W     = 1,
    parameter int DEST_W     = 1,
    parameter int ID_W       = 1,
    parameter int USER_W     = 1
);
    logic [PW-1:0]         left_TDATA;
    logic                  left_TVALID;
    logic                  left_TREADY;

    logic [DATA_WIDTH-1:0] right_TDATA;
    logic                  right_TVALID;
    logic                  right_TREADY;
    logic                  right_TLAST;
    logic [KEEP_W-1:0]     right_TKEEP;
    logic [DEST_W-1:0]     right_TDEST;
    logic [ID_W-1:0]       right_TID;
    logic [USER_W-1:0]     right_TUSER;

    modport slave (
        input  left_TDATA, left_TVALID,
        output left_TREADY,
        output right_TDATA, right_TVALID, right_TLAST,
        output right_TKEEP, right_TDEST, right_TID, right_TUSER,
        input  right_TREADY
    );

    modport master (
        output left_TDATA, left_TVALID,
        input  left_TREADY,
        input  right_TDATA, right_TVALID, right_TLAST,
        input  right_TKEEP, right_TDEST, right_TID, right_TUSER,
        output right_TREADY
    );
endinterface

// File: rtl/axis_unconcat_skid.sv
// Generic WIDTH-bit two-entry register slice. Both ready and valid come
// straight from flops, so neither side sees a combinational path through
// the slice. The skid entry absorbs the one beat that can arrive while the
// downstream stalls.
module axis_skid
    import axis_unconcat_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    skid_state_e      state;
    logic [WIDTH-1:0] skid_data;
    logic             acc;
    logic             deq;

    assign acc = in_valid & in_ready;
    assign deq = out_valid & out_ready;

    // Occupancy FSM with registered ready/valid; reset touches control only
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    in_ready <= 1'b1;
                    if (acc) begin
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (acc && !deq) begin
                        state    <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (!acc && deq) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // Ready is low here, so only a drain can occur
                    if (deq) begin
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Data steering: main entry reloads on accept or skid drain, and the
    // skid entry captures a beat accepted during a stall
    always_ff @(posedge clk) begin
        case (state)
            ST_EMPTY: begin
                if (acc) out_data <= in_data;
            end
            ST_ONE: begin
                if (acc && deq) out_data  <= in_data;
                else if (acc)   skid_data <= in_data;
            end
            ST_FULL: begin
                if (deq) out_data <= skid_data;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/axis_unconcat.sv
// Unpacks a flat word into AXI-Stream DATA plus optional LAST/KEEP/DEST/
// ID/USER. The whole packed word goes through one register slice, and the
// split into fields afterwards is pure wiring. Absent fields drive fixed
// values: LAST=1, KEEP=all ones, and DEST/ID/USER=0.
module axis_unconcat
    import axis_unconcat_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ENABLE_LAST = 1,
    parameter int ENABLE_KEEP = 0,
    parameter int ENABLE_DEST = 0,
    parameter int DEST_WIDTH  = 16,
    parameter int ENABLE_ID   = 0,
    parameter int ID_WIDTH    = 16,
    parameter int ENABLE_USER = 0,
    parameter int USER_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    axis_unconcat_if.slave    bus
);
    localparam int PW = field_lsb(FLD_END, DATA_WIDTH, ENABLE_LAST, ENABLE_KEEP,
                                  ENABLE_DEST, DEST_WIDTH, ENABLE_ID, ID_WIDTH,
                                  ENABLE_USER, USER_WIDTH);

    logic [PW-1:0] word;

    axis_skid #(.WIDTH(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bus.left_TDATA),
        .in_valid  (bus.left_TVALID),
        .in_ready  (bus.left_TREADY),
        .out_data  (word),
        .out_valid (bus.right_TVALID),
        .out_ready (bus.right_TREADY)
    );

    assign bus.right_TDATA = word[field_lsb(FLD_DATA, DATA_WIDTH, ENABLE_LAST, ENABLE_KEEP,
                                            ENABLE_DEST, DEST_WIDTH, ENABLE_ID, ID_WIDTH,
                                            ENABLE_USER, USER_WIDTH) +: DATA_WIDTH];

    if (ENABLE_LAST != 0) begin : g_last
        assign bus.right_TLAST = word[field_lsb(FLD_LAST, DATA_WIDTH, ENABLE_LAST, ENABLE_KEEP,
                                                ENABLE_DEST, DEST_WIDTH, ENABLE_ID, ID_WIDTH,
                                                ENABLE_USER, USER_WIDTH)];
    end else begin : g_no_last
        assign bus.right_TLAST = 1'b1;
    end

    if (ENABLE_KEEP != 0) begin : g_keep
        assign bus.right_TKEEP = word[field_lsb(FLD_KEEP, DATA_WIDTH, ENABLE_LAST, ENABLE_KEEP,
                                                ENABLE_DEST, DEST_WIDTH, ENABLE_ID, ID_WIDTH,
                                                ENABLE_USER, USER_WIDTH) +: keep_w(DATA_WIDTH)];
    end else begin : g_no_keep
        assign bus.right_TKEEP = '1;
    end

    if (ENABLE_DEST != 0) begin : g_dest
        assign bus.right_TDEST = word[field_lsb(FLD_DEST, DATA_WIDTH, ENABLE_LAST, ENABLE_KEEP,
                                                ENABLE_DEST, DEST_WIDTH, ENABLE_ID, ID_WIDTH,
                                                ENABLE_USER, USER_WIDTH) +: DEST_WIDTH];
    end else begin : g_no_dest
        assign bus.right_TDEST = '0;
    end

    if (ENABLE_ID != 0) begin : g_id
        assign bus.right_TID = word[field_lsb(FLD_ID, DATA_WIDTH, ENABLE_LAST, ENABLE_KEEP,
                                              ENABLE_DEST, DEST_WIDTH, ENABLE_ID, ID_WIDTH,
                                              ENABLE_USER, USER_WIDTH) +: ID_WIDTH];
    end else begin : g_no_id
        assign bus.right_TID = '0;
    end

    if (ENABLE_USER != 0) begin : g_user
        assign bus.right_TUSER = word[0 +: USER_WIDTH];
    end else begin : g_no_user
        assign bus.right_TUSER = '0;
    end
endmodule

// File: tb/tb_axis_unconcat.sv
// Directed and randomized checks of axis_unconcat.
// DUT A: DATA+LAST+KEEP, packed width 37.
// DUT B: DATA+LAST+KEEP+DEST(4), packed width 41.
// Inputs are driven and outputs sampled on the falling edge.
module tb_axis_unconcat;
    import axis_unconcat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    axis_unconcat_if #(.DATA_WIDTH(32), .PW(37), .KEEP_W(4)) ifa ();
    axis_unconcat_if #(.DATA_WIDTH(32), .PW(41), .KEEP_W(4), .DEST_W(4)) ifb ();

    axis_unconcat #(
        .DATA_WIDTH(32), .ENABLE_LAST(1), .ENABLE_KEEP(1),
        .ENABLE_DEST(0), .DEST_WIDTH(16), .ENABLE_ID(0), .ID_WIDTH(16),
        .ENABLE_USER(0), .USER_WIDTH(16)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    axis_unconcat #(
        .DATA_WIDTH(32), .ENABLE_LAST(1), .ENABLE_KEEP(1),
        .ENABLE_DEST(1), .DEST_WIDTH(4), .ENABLE_ID(0), .ID_WIDTH(16),
        .ENABLE_USER(0), .USER_WIDTH(16)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    function automatic logic [36:0] pk_a(input logic [31:0] d, input logic l, input logic [3:0] k);
        return {d, l, k};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ifa.left_TVALID = 1'b0; ifa.left_TDATA = '0; ifa.right_TREADY = 1'b0;
        ifb.left_TVALID = 1'b0; ifb.left_TDATA = '0; ifb.right_TREADY = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifa.right_TVALID, ifa.left_TREADY} !== 2'b00) begin
            errors++; $display("FAIL reset_a: valid/ready=%b want 00", {ifa.right_TVALID, ifa.left_TREADY});
        end
        checks++;
        if ({ifb.right_TVALID, ifb.left_TREADY} !== 2'b00) begin
            errors++; $display("FAIL reset_b: valid/ready=%b want 00", {ifb.right_TVALID, ifb.left_TREADY});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifa.right_TVALID, ifa.left_TREADY} !== 2'b01) begin
            errors++; $display("FAIL reset_release_a: valid/ready=%b want 01", {ifa.right_TVALID, ifa.left_TREADY});
        end
        checks++;
        if ({ifb.right_TVALID, ifb.left_TREADY} !== 2'b01) begin
            errors++; $display("FAIL reset_release_b: valid/ready=%b want 01", {ifb.right_TVALID, ifb.left_TREADY});
        end
    endtask

    task automatic test_single();
        ifa.left_TDATA = pk_a(32'hDEADBEEF, 1'b1, 4'hF);
        ifa.left_TVALID = 1'b1;
        ifa.right_TREADY = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifa.right_TVALID, ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP} !== {1'b1, 32'hDEADBEEF, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL single_beat: v=%b data=%h last=%b keep=%h want v=1 data=deadbeef last=1 keep=f",
                     ifa.right_TVALID, ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP);
        end
        checks++;
        if ({ifa.right_TDEST, ifa.right_TID, ifa.right_TUSER} !== 3'b000) begin
            errors++; $display("FAIL disabled_fields: dest/id/user=%b want 000",
                               {ifa.right_TDEST, ifa.right_TID, ifa.right_TUSER});
        end
        ifa.left_TVALID = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.right_TVALID !== 1'b0) begin
            errors++; $display("FAIL single_drain: valid=%b want 0", ifa.right_TVALID);
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] exp;
        ifa.right_TREADY = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                exp = pk_a(32'hA000_0000 | 32'(k - 1), 1'((k - 1) & 1), 4'(k));
                checks++;
                if ({ifa.right_TVALID, ifa.left_TREADY, ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP} !== {2'b11, exp}) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: v=%b rdy=%b word=%h want v=1 rdy=1 word=%h", k - 1,
                             ifa.right_TVALID, ifa.left_TREADY,
                             {ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP}, exp);
                end
            end
            if (k < 8) begin
                ifa.left_TDATA = pk_a(32'hA000_0000 | 32'(k), 1'(k & 1), 4'(k + 1));
                ifa.left_TVALID = 1'b1;
            end else begin
                ifa.left_TVALID = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (ifa.right_TVALID !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: valid=%b want 0", ifa.right_TVALID);
        end
    endtask

    task automatic test_backpressure();
        // per-cycle drive, then what must be visible at the next falling edge
        logic        drv_v  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        int          drv_i  [8] = '{0, 1, 2, 2, 2, 2, 2, 2};
        logic        drv_rr [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
        logic        exp_v  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic        exp_r  [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        int          exp_i  [8] = '{0, 0, 0, 0, 0, 1, 2, 0};
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                checks++;
                if (ifa.right_TVALID !== exp_v[c] || ifa.left_TREADY !== exp_r[c] ||
                    (exp_v[c] && ifa.right_TDATA !== 32'hB000_0000 + 32'(exp_i[c]))) begin
                    errors++;
                    $display("FAIL stall_cyc%0d: v=%b rdy=%b data=%h want v=%b rdy=%b data=%h", c,
                             ifa.right_TVALID, ifa.left_TREADY, ifa.right_TDATA,
                             exp_v[c], exp_r[c], 32'hB000_0000 + 32'(exp_i[c]));
                end
            end
            ifa.left_TVALID  = drv_v[c];
            ifa.left_TDATA   = pk_a(32'hB000_0000 + 32'(drv_i[c]), 1'b1, 4'hF);
            ifa.right_TREADY = drv_rr[c];
            @(negedge clk);
        end
    endtask

    task automatic test_dest();
        ifb.left_TDATA = {32'h12345678, 1'b0, 4'h3, 4'hA};
        ifb.left_TVALID = 1'b1;
        ifb.right_TREADY = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifb.right_TVALID, ifb.right_TDATA, ifb.right_TLAST, ifb.right_TKEEP, ifb.right_TDEST} !==
            {1'b1, 32'h12345678, 1'b0, 4'h3, 4'hA}) begin
            errors++;
            $display("FAIL dest_unpack: v=%b data=%h last=%b keep=%h dest=%h want v=1 data=12345678 last=0 keep=3 dest=a",
                     ifb.right_TVALID, ifb.right_TDATA, ifb.right_TLAST, ifb.right_TKEEP, ifb.right_TDEST);
        end
        checks++;
        if ({ifb.right_TID, ifb.right_TUSER} !== 2'b00) begin
            errors++; $display("FAIL dest_idle_fields: id/user=%b want 00", {ifb.right_TID, ifb.right_TUSER});
        end
        ifb.left_TVALID = 1'b0;
        @(negedge clk);
        checks++;
        if (ifb.right_TVALID !== 1'b0) begin
            errors++; $display("FAIL dest_drain: valid=%b want 0", ifb.right_TVALID);
        end
    endtask

    task automatic test_reset_full();
        ifa.right_TREADY = 1'b0;
        ifa.left_TVALID = 1'b1;
        ifa.left_TDATA = pk_a(32'hC000_0000, 1'b0, 4'h1);
        @(negedge clk);
        ifa.left_TDATA = pk_a(32'hC000_0001, 1'b0, 4'h2);
        @(negedge clk);
        checks++;
        if ({ifa.right_TVALID, ifa.left_TREADY, ifa.right_TDATA} !== {2'b10, 32'hC000_0000}) begin
            errors++; $display("FAIL full_before_rst: v=%b rdy=%b data=%h want v=1 rdy=0 data=c0000000",
                               ifa.right_TVALID, ifa.left_TREADY, ifa.right_TDATA);
        end
        rst = 1'b1;
        ifa.left_TDATA = pk_a(32'hC000_0002, 1'b0, 4'h3);
        @(negedge clk);
        checks++;
        if ({ifa.right_TVALID, ifa.left_TREADY} !== 2'b00) begin
            errors++; $display("FAIL rst_in_full: valid/ready=%b want 00", {ifa.right_TVALID, ifa.left_TREADY});
        end
        rst = 1'b0;
        ifa.left_TVALID = 1'b0;
        ifa.right_TREADY = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifa.right_TVALID, ifa.left_TREADY} !== 2'b01) begin
            errors++; $display("FAIL rst_release: valid/ready=%b want 01", {ifa.right_TVALID, ifa.left_TREADY});
        end
        @(negedge clk);
        checks++;
        if (ifa.right_TVALID !== 1'b0) begin
            errors++; $display("FAIL stale_beat: valid=%b data=%h want valid 0", ifa.right_TVALID, ifa.right_TDATA);
        end
        ifa.left_TVALID = 1'b1;
        ifa.left_TDATA = pk_a(32'hC000_0003, 1'b1, 4'h4);
        @(negedge clk);
        checks++;
        if ({ifa.right_TVALID, ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP} !== {1'b1, 32'hC000_0003, 1'b1, 4'h4}) begin
            errors++; $display("FAIL post_rst_beat: v=%b data=%h want v=1 data=c0000003",
                               ifa.right_TVALID, ifa.right_TDATA);
        end
        ifa.left_TVALID = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [36:0] q[$];
        logic [36:0] exp;
        logic [36:0] prev_word;
        logic [63:0] r;
        logic        in_fire;
        logic        out_fire;
        logic        stall_prev;
        int          sent;
        int          rcvd;
        int          cyc;
        sent = 0; rcvd = 0; cyc = 0;
        stall_prev = 1'b0; in_fire = 1'b0; prev_word = '0;
        ifa.left_TVALID = 1'b0;
        while (rcvd < N && cyc < 60000) begin
            // an output stalled last cycle must be unchanged now
            if (stall_prev) begin
                checks++;
                if ({ifa.right_TVALID, ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP} !== {1'b1, prev_word}) begin
                    errors++; $display("FAIL rand_hold cyc%0d: v=%b word=%h want v=1 word=%h", cyc,
                                       ifa.right_TVALID, {ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP}, prev_word);
                end
            end
            if (in_fire) ifa.left_TVALID = 1'b0;
            if (!ifa.left_TVALID && sent < N && $urandom_range(0, 9) < 7) begin
                r = {$urandom(), $urandom()};
                ifa.left_TDATA = r[36:0];
                ifa.left_TVALID = 1'b1;
            end
            ifa.right_TREADY = ($urandom_range(0, 9) < 7);
            in_fire  = ifa.left_TVALID & ifa.left_TREADY;
            out_fire = ifa.right_TVALID & ifa.right_TREADY;
            if (out_fire) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_beat cyc%0d: word=%h with nothing sent", cyc,
                                       {ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP});
                end else begin
                    exp = q.pop_front();
                    if ({ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP} !== exp) begin
                        errors++; $display("FAIL rand_beat%0d: word=%h want %h", rcvd,
                                           {ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP}, exp);
                    end
                end
                rcvd++;
            end
            if (in_fire) begin
                q.push_back(ifa.left_TDATA);
                sent++;
            end
            stall_prev = ifa.right_TVALID & ~ifa.right_TREADY;
            prev_word  = {ifa.right_TDATA, ifa.right_TLAST, ifa.right_TKEEP};
            cyc++;
            @(negedge clk);
        end
        ifa.left_TVALID = 1'b0;
        checks++;
        if (rcvd != N) begin
            errors++; $display("FAIL rand_timeout: received %0d beats want %0d", rcvd, N);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_dest();
        test_reset_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
